// File: rtl/scan_sequencer_pkg.sv
// Shared scan definitions: FSM state encoding and terminal select codes.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  localparam logic [2:0] SEL_LO = 3'd0;
  localparam logic [2:0] SEL_HI = 3'd7;

  function automatic logic [2:0] first_sel(input logic descending);
    return descending ? SEL_HI : SEL_LO;
  endfunction

  function automatic logic [2:0] last_sel(input logic descending);
    return descending ? SEL_LO : SEL_HI;
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// Existing 3-to-8 one-hot decoder with active-high enable.
module decoder3to8 (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/scan_sequencer_dwell_counter.sv
// Dwell counter: clearable up-counter with terminal-count flag against a limit.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + W'(1);
  end

  assign tc = (count == limit);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select through 0..7 or 7..0,
// holding each code for a programmable dwell; one-shot or continuous.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  scan_state_t        state_q, state_d;
  logic               dir_q, dir_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         sel_d;
  logic               en_d, busy_d, done_d, wrap_d;
  logic               cnt_clr, cnt_inc, cnt_tc;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (dwell_q),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
      sel     <= SEL_LO;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      dwell_q <= dwell_d;
      sel     <= sel_d;
      en      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight off a flop.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    dwell_d = dwell_q;
    sel_d   = sel;
    en_d    = en;
    busy_d  = busy;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          dir_d   = dir;
          cont_d  = cont;
          dwell_d = dwell;
          sel_d   = first_sel(dir);
          cnt_clr = 1'b1;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          cnt_clr = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (sel == last_sel(dir_q) && !cont_q) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Modulo-8 stepping makes the continuous wrap fall out naturally.
            sel_d  = dir_q ? sel - 3'd1 : sel + 3'd1;
            wrap_d = (sel == last_sel(dir_q));
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer; expected sequences are derived
// from scan position arithmetic (cycle / (dwell+1)) rather than FSM state.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir, cont;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       en, busy, done, wrap;
  logic [7:0] dec;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .cont  (cont),
    .dwell (dwell),
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  decoder3to8 u_dec (
    .a  (sel),
    .en (en),
    .y  (dec)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] es, input logic een,
                            input logic ebusy, input logic edone, input logic ewrap);
    logic [7:0] edec;
    edec = een ? (8'd1 << es) : 8'd0;
    chk({tag, ".sel"},  32'(sel),  32'(es));
    chk({tag, ".en"},   32'(en),   32'(een));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(done), 32'(edone));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
    chk({tag, ".dec"},  32'(dec),  32'(edec));
  endtask

  // One-shot scan: 8 selects x (dw+1) cycles, one DONE cycle, then idle.
  task automatic run_oneshot(input logic d, input logic [7:0] dw, input bit perturb,
                             input bit stop_in_done);
    logic [2:0] es;
    dir = d; cont = 1'b0; dwell = dw; stop = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned k = 0; k <= 32'(dw); k++) begin
        es = d ? 3'(7 - i) : 3'(i);
        check_outs("run", es, 1'b1, 1'b1, 1'b0, 1'b0);
        if (perturb) begin
          start = 1'($urandom);
          dir   = 1'($urandom);
          cont  = 1'($urandom);
          dwell = 8'($urandom);
        end
        step;
      end
    end
    start = 1'b0;
    es = d ? 3'd0 : 3'd7;
    check_outs("done", es, 1'b0, 1'b1, 1'b1, 1'b0);
    stop = stop_in_done;
    step;
    stop = 1'b0;
    check_outs("idle", es, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Continuous scan observed for ncyc cycles past start, then stopped.
  task automatic run_cont(input logic d, input logic [7:0] dw, input int unsigned ncyc);
    int unsigned per, pos, idx;
    logic [2:0]  es;
    logic        ew;
    per = 32'(dw) + 1;
    es = 3'd0;
    dir = d; cont = 1'b1; dwell = dw; stop = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    for (int unsigned t = 0; t <= ncyc; t++) begin
      pos = t / per;
      idx = pos % 8;
      es  = d ? 3'(7 - idx) : 3'(idx);
      ew  = (pos >= 8) && (idx == 0) && (t % per == 0);
      check_outs("cont", es, 1'b1, 1'b1, 1'b0, ew);
      if (t < ncyc) step;
    end
    stop = 1'b1;
    step;
    stop = 1'b0;
    check_outs("stop", es, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    check_outs("stop_idle", es, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0; dwell = 8'd0;
    #2;
    check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    step;
    rst = 1'b0;
    step;
    check_outs("post_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_oneshot(1'b0, 8'd0, 1'b0, 1'b0);
    run_oneshot(1'b1, 8'd2, 1'b0, 1'b0);

    // Start and stop together in IDLE: stop wins, sel keeps its last value.
    start = 1'b1; stop = 1'b1; dir = 1'b0; dwell = 8'd1;
    step;
    start = 1'b0; stop = 1'b0;
    check_outs("start_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    check_outs("start_stop2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_cont(1'b0, 8'd1, 21);
    run_cont(1'b1, 8'd0, 19);

    run_oneshot(1'b0, 8'd1, 1'b1, 1'b1);
    for (int unsigned n = 0; n < 4; n++)
      run_oneshot(1'($urandom), 8'($urandom_range(0, 4)), 1'b1, 1'($urandom));
    run_cont(1'($urandom), 8'($urandom_range(0, 3)), 32'($urandom_range(10, 40)));

    // Asynchronous reset mid-dwell at sel=4: 17 cycles into a dwell=3 ascending scan.
    dir = 1'b0; cont = 1'b0; dwell = 8'd3; start = 1'b1;
    step;
    start = 1'b0;
    repeat (17) step;
    check_outs("pre_rst", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    rst = 1'b0;
    step;
    check_outs("rst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_oneshot(1'b0, 8'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter: DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a scan; sampled only in IDLE.
REQ-005 SHALL have port: stop  input  1  abort request; sampled in every state.
REQ-006 SHALL have port: dir  input  1  0 = ascending scan (0..7), 1 = descending scan (7..0); latched on start.
REQ-007 SHALL have port: cont  input  1  0 = one-shot scan, 1 = continuous scan; latched on start.
REQ-008 SHALL have port: dwell  input  DWELL_W  cycles-per-select minus one; latched on start.
REQ-009 SHALL have port: sel  output  3  select code driven into the downstream 3-to-8 decoder.
REQ-010 SHALL have port: en  output  1  decoder enable; high only while a select is being presented.
REQ-011 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at the end of a one-shot scan.
REQ-013 SHALL have port: wrap  output  1  one-cycle pulse when a continuous scan wraps.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 SHALL register all outputs; no output shall be combinational from any input.
REQ-016 In IDLE with start=1 and stop=0, SHALL latch dir, cont and dwell, load sel (0 if dir=0, 7 if dir=1), clear the dwell count and enter RUN; en and busy rise on the next edge.
REQ-017 In RUN, SHALL hold each sel value for exactly dwell+1 cycles with en=1; dwell=0 means sel advances every cycle.
REQ-018 In RUN, when the dwell count equals the latched dwell value, SHALL step sel by +1 (dir=0) or -1 (dir=1) modulo 8 and clear the dwell count.
REQ-019 One-shot: after the terminal select (7 ascending, 0 descending) completes its dwell, SHALL enter DONE for one cycle with en=0, busy=1, done=1, then return to IDLE with sel unchanged.
REQ-020 Continuous: at the terminal select, SHALL wrap (7->0 or 0->7), pulse wrap for one cycle coincident with the first cycle of the new select, and remain in RUN.
REQ-021 A one-shot scan SHALL therefore take exactly 8*(dwell+1) cycles in RUN, followed by 1 cycle in DONE.
REQ-022 start asserted while in RUN or DONE SHALL be ignored; latched parameters SHALL NOT change mid-scan.
REQ-023 stop=1 in RUN SHALL force IDLE on the next edge with en=0 and busy=0, leave sel holding its last value, and produce no done pulse.
REQ-024 stop=1 together with start=1 in IDLE SHALL keep the block in IDLE (stop wins).
REQ-025 stop=1 in DONE SHALL NOT suppress the done pulse already being driven; the block returns to IDLE as normal.
REQ-026 Changes to dir, cont or dwell inputs during RUN SHALL have no effect until the next start.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state to IDLE, sel=0, en=0, busy=0, done=0, wrap=0 and the dwell count to 0.
REQ-028 Reset asserted mid-scan SHALL abandon the scan with no done or wrap pulse; the first start after deassertion begins a fresh scan.

Structure
REQ-029 State encodings (IDLE, RUN, DONE) and the terminal select constants (0, 7) SHALL live in a shared scan_pkg include for reuse by the bench.
REQ-030 The dwell counter SHALL be a sub-module, dwell_counter (load/clear, increment, terminal-count flag, DWELL_W wide).
REQ-031 sel and en SHALL connect directly to the a and en ports of the existing 3-to-8 decoder at top level with no glue logic.

Verification
REQ-032 Reset then start with dir=0, cont=0, dwell=0 -> sel 0,1,...,7 on 8 consecutive cycles with en=1, then done=1 for 1 cycle, then IDLE with sel=7.
REQ-033 start with dir=1, cont=0, dwell=2 -> each of sel 7..0 held 3 cycles (24 cycles total), then done pulse; the bench checks the decoder output walks one-hot from bit 7 to bit 0.
REQ-034 start with dir=0, cont=1, dwell=1 -> after 16 cycles sel returns to 0 with wrap=1 for 1 cycle; no done ever; stop then drops en and busy on the next edge.
REQ-035 start during RUN with dir toggled and dwell changed -> scan continues unaffected; start and stop asserted in the same IDLE cycle -> stays in IDLE.
REQ-036 Assert rst asynchronously mid-dwell at sel=4 -> outputs go to reset values before the next clk edge; a following start scans again from 0.
